// File: rtl/serial_fadd_ctrl.sv
// serial_fadd_ctrl: bit-serial adder, one full-adder slice reused LSB-first over NBITS cycles
module serial_fadd_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic             in_cin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_sum,
  output logic             out_cout
);
  localparam int CW = $clog2(NBITS) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_sum;
  logic             r_carry;
  logic             w_s;
  logic             w_c;
  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign in_rdy   = r_state == IDLE;
  assign out_val  = r_state == DONE;
  assign out_sum  = r_sum;
  assign out_cout = r_carry;
  // FSM and datapath: load in IDLE, shift one slice per CALC cycle, hold result in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_val) begin
          r_a     <= in_a;
          r_b     <= in_b;
          r_carry <= in_cin;
          r_sum   <= '0;
          r_count <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_sum   <= (r_sum >> 1) | (NBITS'(w_s) << (NBITS - 1));
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(NBITS - 1)) r_state <= DONE;
        end
        DONE: if (out_rdy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_fadd_ctrl.md
Name: serial_fadd_ctrl

Overview:
- Bit-serial adder controller: one full-adder slice (sum = a^b^c, carry = majority(a,b,c)) is time-multiplexed over NBITS cycles to add two NBITS-bit operands, LSB first.
- Operands arrive on a val/rdy request interface; the result leaves on a val/rdy response interface.
- Area-lean alternative to a ripple adder, for slow-path arithmetic next to the combinational gate-level blocks.

Parameters:
NBITS, 8, operand/result width; legal range 1..32

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_val  input  1  request valid
in_rdy  output  1  request ready
in_a  input  NBITS  operand A
in_b  input  NBITS  operand B
in_cin  input  1  carry-in
out_val  output  1  response valid
out_rdy  input  1  response ready
out_sum  output  NBITS  sum, (in_a + in_b + in_cin) mod 2^NBITS
out_cout  output  1  carry-out of the MSB

Behaviour:
- State registers: state, count (clog2(NBITS)+1 bits), a_reg, b_reg, carry_reg, sum_reg.
- Three-state FSM: IDLE, CALC, DONE.
- reset_n low, asynchronously:
  - state=IDLE; all datapath registers cleared to 0.
  - Therefore in_rdy=1, out_val=0, out_sum=0, out_cout=0 while reset is held and on the first cycle after release.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&in_rdy: a_reg<=in_a, b_reg<=in_b, carry_reg<=in_cin, sum_reg<=0, count<=0, next state CALC.
  - Otherwise hold.
- CALC:
  - in_rdy=0, out_val=0.
  - Each cycle, the slice consumes a_reg[0], b_reg[0], carry_reg.
  - The sum bit shifts into sum_reg from the MSB side (sum_reg <= {s, sum_reg[NBITS-1:1]}).
  - a_reg and b_reg shift right by 1; carry_reg <= slice carry; count++.
  - When count==NBITS-1, next state DONE.
- DONE:
  - out_val=1, out_sum=sum_reg, out_cout=carry_reg, in_rdy=0.
  - On out_rdy, next state IDLE; otherwise hold, with outputs stable.
- Latency:
  - Request accepted at edge T → out_val first high in the cycle after edge T+NBITS (NBITS CALC cycles).
  - Minimum issue interval is NBITS+2 cycles: accept, NBITS compute, respond.
- No bypass: a new request is never accepted in the same cycle a response is taken. in_rdy is 0 in DONE even if out_rdy=1.
- in_val in CALC/DONE is ignored; the operands are not sampled.
- out_sum and out_cout are driven from the registers in every state. They are meaningful only while out_val=1 and must not change while out_val=1 and out_rdy=0.
- in_rdy and out_val are decoded purely from state, with no combinational path from in_val or out_rdy.
- Reset asserted mid-CALC or mid-DONE aborts the operation, with no response emitted; the block returns to IDLE with all registers cleared.
- NBITS=1: exactly one CALC cycle; out_cout is the single-slice carry.
- Arithmetic is unsigned modulo 2^NBITS; overflow is reported only via out_cout.

Test Plan:
- NBITS=8, reset_n low 2 cycles then high:
  - During reset: in_rdy=1, out_val=0, out_sum=0x00, out_cout=0.
  - Then send a=0x5A, b=0x33, cin=0 with out_rdy=1 → out_val rises exactly 9 cycles after the accept edge; out_sum=0x8D, out_cout=0; one-cycle pulse.
- a=0xFF, b=0x01, cin=0 → out_sum=0x00, out_cout=1.
- a=0xFF, b=0xFF, cin=1 → out_sum=0xFF, out_cout=1.
- a=0x00, b=0x00, cin=1 → out_sum=0x01, out_cout=0.
- Backpressure on a=0x12, b=0x34, cin=0:
  - out_rdy held 0 for 5 cycles → out_val=1 and out_sum=0x46 stable throughout; in_rdy=0.
  - in_val=1 with a=0xAA during CALC/DONE is not accepted.
  - After out_rdy=1 for one cycle → IDLE, in_rdy=1, and 0xAA is accepted next.
- Reset mid-operation: accept a=0x7F, b=0x01, pull reset_n low at CALC cycle 4 → out_val never asserts.
  - After release, a=0x03, b=0x04, cin=0 → out_sum=0x07, out_cout=0, 9 cycles later.
- Back-to-back stream of 20 random requests with in_val=1 and out_rdy=1 throughout:
  - Each accepted every 10 cycles (NBITS+2).
  - Every result matches (a+b+cin) mod 256 and the carry matches bit 8 of the true sum.
